// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: FSM states, the zero register and field widths.
package pipe_hazard_ctrl_pkg;

  // Register-field width used by the pipeline registers and the hazard compare.
  localparam int REG_W = 5;

  // Width of the internal consecutive-freeze counter.
  localparam int WAIT_W = 16;

  // X31 reads as zero, so a write to it can never create a dependency.
  localparam logic [REG_W-1:0] XZR = 5'd31;

  // Controller state: normal flow, or holding for a data-memory access.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: step by one when enabled unless already saturated.
  always_comb begin
    count_d = count_q;
    if (enable && !(&count_q)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage LEGv8 pipeline.
// Drives the write enables and flushes of the pipeline registers, detects
// load-use hazards, flushes wrong-path work on a taken branch, freezes the
// pipeline while data memory is busy, and keeps a wait timeout plus
// saturating performance counters.
//
// Control outputs are Mealy outputs with a fixed priority:
// reset > freeze > taken branch > load-use > normal flow.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rmt,
  input  logic             id_uses_rn,
  input  logic             id_uses_rmt,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             idex_memread,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             pipe_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output state_e           dbg_state
);

  localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_run_q, wait_run_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic load_use;
  logic freeze;
  logic stall_en;
  logic flush_en;
  logic wait_en;

  // A load in ID/EX feeding a source of the IF/ID instruction; XZR never counts.
  assign load_use = idex_memread && (idex_rd != XZR) &&
                    ((id_uses_rn  && (idex_rd == id_rn)) ||
                     (id_uses_rmt && (idex_rd == id_rmt)));

  // Memory access outstanding and not completing this cycle.
  assign freeze = ((state_q == RUN) || (state_q == MEM_WAIT)) &&
                  dmem_req && !dmem_ready;

  // Priority-encoded pipeline control and counter enables.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    pipe_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    stall_en    = 1'b0;
    flush_en    = 1'b0;
    wait_en     = 1'b0;
    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (freeze) begin
      // Everything holds, so a pending branch or hazard is simply deferred.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_write = 1'b0;
      wait_en    = 1'b1;
    end else if (branch_taken) begin
      // The dependent instruction of any load-use is itself being flushed.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      flush_en    = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, let the load advance, insert one bubble.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      stall_en   = 1'b1;
    end
  end

  // Next state: enter the wait on a freeze, leave once memory completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (freeze)  state_d = MEM_WAIT;
      MEM_WAIT: if (!freeze) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Consecutive-freeze length and the sticky timeout flag.
  always_comb begin
    wait_run_d    = '0;
    mem_timeout_d = mem_timeout_q;
    if (freeze) begin
      wait_run_d = (&wait_run_q) ? wait_run_q : wait_run_q + WAIT_W'(1);
      if (wait_run_q == TMO_LAST) begin
        mem_timeout_d = 1'b1;
      end
    end
  end

  // State, wait-length and timeout registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      wait_run_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_run_q    <= wait_run_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign dbg_state   = state_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (stall_en),
    .count   (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (flush_en),
    .count   (flush_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_wait_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (wait_en),
    .count   (wait_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a default instance (TIMEOUT 64, 16-bit counters)
// and a small one (TIMEOUT 4, 4-bit counters) share every input.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [4:0] id_rn, id_rmt, idex_rd;
  logic id_uses_rn, id_uses_rmt, idex_memread, branch_taken, dmem_req, dmem_ready;

  logic a_pc, a_ifid, a_pipe, a_ifl, a_idf, a_exf, a_to;
  logic b_pc, b_ifid, b_pipe, b_ifl, b_idf, b_exf, b_to;
  logic [15:0] a_stall, a_flush, a_wait;
  logic [3:0]  b_stall, b_flush, b_wait;
  state_e a_st, b_st;

  pipe_hazard_ctrl #(.TIMEOUT(64), .CNT_W(16)) dut_a (
    .clock(clock), .reset_n(reset_n), .id_rn(id_rn), .id_rmt(id_rmt),
    .id_uses_rn(id_uses_rn), .id_uses_rmt(id_uses_rmt), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(a_pc), .ifid_write(a_ifid), .pipe_write(a_pipe),
    .ifid_flush(a_ifl), .idex_flush(a_idf), .exmem_flush(a_exf),
    .mem_timeout(a_to), .stall_cnt(a_stall), .flush_cnt(a_flush),
    .wait_cnt(a_wait), .dbg_state(a_st)
  );

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .id_rn(id_rn), .id_rmt(id_rmt),
    .id_uses_rn(id_uses_rn), .id_uses_rmt(id_uses_rmt), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(b_pc), .ifid_write(b_ifid), .pipe_write(b_pipe),
    .ifid_flush(b_ifl), .idex_flush(b_idf), .exmem_flush(b_exf),
    .mem_timeout(b_to), .stall_cnt(b_stall), .flush_cnt(b_flush),
    .wait_cnt(b_wait), .dbg_state(b_st)
  );

  wire [5:0] a_ctl = {a_pc, a_ifid, a_pipe, a_ifl, a_idf, a_exf};
  wire [5:0] b_ctl = {b_pc, b_ifid, b_pipe, b_ifl, b_idf, b_exf};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Index 0 models dut_a, index 1 models dut_b.
  int tmo[2]  = '{64, 4};
  int cmax[2] = '{65535, 15};
  int m_stall[2], m_flush[2], m_wait[2], m_run[2];
  bit m_to[2];
  bit m_waiting;  // a freeze was seen on the previous edge

  function automatic bit model_lu();
    return idex_memread && (idex_rd != 5'd31) &&
           ((id_uses_rn && idex_rd == id_rn) || (id_uses_rmt && idex_rd == id_rmt));
  endfunction

  function automatic bit model_frz();
    return dmem_req && !dmem_ready;
  endfunction

  // Expected {pc_write, ifid_write, pipe_write, ifid_flush, idex_flush, exmem_flush}.
  function automatic logic [5:0] model_ctl();
    if (!reset_n)          return 6'b000111;
    else if (model_frz())  return 6'b000000;
    else if (branch_taken) return 6'b111111;
    else if (model_lu())   return 6'b001010;
    else                   return 6'b111000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_stall[i] = 0; m_flush[i] = 0; m_wait[i] = 0; m_run[i] = 0; m_to[i] = 0;
    end
    m_waiting = 0;
  endtask

  task automatic model_edge();
    bit f, b, l;
    f = model_frz(); b = branch_taken; l = model_lu();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = f ? m_run[i] + 1 : 0;
      if (m_run[i] >= tmo[i]) m_to[i] = 1;
      if (f)      m_wait[i]  = (m_wait[i]  < cmax[i]) ? m_wait[i]  + 1 : cmax[i];
      else if (b) m_flush[i] = (m_flush[i] < cmax[i]) ? m_flush[i] + 1 : cmax[i];
      else if (l) m_stall[i] = (m_stall[i] < cmax[i]) ? m_stall[i] + 1 : cmax[i];
    end
    m_waiting = f;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_state_a"}, int'(a_st), m_waiting ? 1 : 0);
    chk({tag, "_state_b"}, int'(b_st), m_waiting ? 1 : 0);
    chk({tag, "_stall_a"}, a_stall, m_stall[0]);
    chk({tag, "_flush_a"}, a_flush, m_flush[0]);
    chk({tag, "_wait_a"},  a_wait,  m_wait[0]);
    chk({tag, "_to_a"},    a_to,    m_to[0]);
    chk({tag, "_stall_b"}, b_stall, m_stall[1]);
    chk({tag, "_flush_b"}, b_flush, m_flush[1]);
    chk({tag, "_wait_b"},  b_wait,  m_wait[1]);
    chk({tag, "_to_b"},    b_to,    m_to[1]);
  endtask

  // ---------------- driver ----------------
  task automatic set_in(input logic [4:0] rn, input logic [4:0] rmt, input logic urn,
                        input logic urmt, input logic [4:0] rd, input logic mr,
                        input logic br, input logic req, input logic rdy);
    id_rn = rn; id_rmt = rmt; id_uses_rn = urn; id_uses_rmt = urmt;
    idex_rd = rd; idex_memread = mr; branch_taken = br; dmem_req = req; dmem_ready = rdy;
  endtask

  // One cycle, entered and left just after a falling edge.
  task automatic do_cycle(input string tag);
    #1;
    chk({tag, "_ctl_a"}, a_ctl, model_ctl());
    chk({tag, "_ctl_b"}, b_ctl, model_ctl());
    @(posedge clock);
    model_edge();
    @(negedge clock);
    chk_regs(tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] rn, rmt, rd;
    logic urn, urmt, mr, br, req, rdy;
    logic [5:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] rn, input logic [4:0] rmt, input logic urn,
                              input logic urmt, input logic [4:0] rd, input logic mr,
                              input logic br, input logic req, input logic rdy,
                              input logic [5:0] exp);
    vec_t v;
    v.rn = rn; v.rmt = rmt; v.urn = urn; v.urmt = urmt; v.rd = rd; v.mr = mr;
    v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  vec_t tbl[11];

  initial begin
    // LDUR X2 in ID/EX, ADD reading X2 in IF/ID: one bubble, then normal flow.
    tbl[0]  = mk(5'd2,  5'd0,  1, 0, 5'd2,  1, 0, 0, 0, 6'b001010);
    tbl[1]  = mk(5'd2,  5'd0,  1, 0, 5'd9,  0, 0, 0, 0, 6'b111000);
    // Load into XZR never stalls.
    tbl[2]  = mk(5'd31, 5'd31, 1, 1, 5'd31, 1, 0, 0, 0, 6'b111000);
    // Hazard through the Rm/Rt source.
    tbl[3]  = mk(5'd3,  5'd7,  1, 1, 5'd7,  1, 0, 0, 0, 6'b001010);
    // Matching field but the source is not read.
    tbl[4]  = mk(5'd5,  5'd5,  0, 0, 5'd5,  1, 0, 0, 0, 6'b111000);
    // Matching register but the ID/EX instruction is not a load.
    tbl[5]  = mk(5'd6,  5'd0,  1, 0, 5'd6,  0, 0, 0, 0, 6'b111000);
    // Taken branch overrides a load-use hazard.
    tbl[6]  = mk(5'd2,  5'd0,  1, 0, 5'd2,  1, 1, 0, 0, 6'b111111);
    tbl[7]  = mk(5'd0,  5'd0,  0, 0, 5'd0,  0, 1, 0, 0, 6'b111111);
    // Freeze beats a pending branch.
    tbl[8]  = mk(5'd0,  5'd0,  0, 0, 5'd0,  0, 1, 1, 0, 6'b000000);
    // Ready in the same cycle as the request: no freeze; hazard still applies.
    tbl[9]  = mk(5'd4,  5'd0,  1, 0, 5'd4,  1, 0, 1, 1, 6'b001010);
    tbl[10] = mk(5'd1,  5'd2,  1, 1, 5'd3,  1, 0, 1, 1, 6'b111000);
  end

  // ---------------- test sequence ----------------
  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    chk("rst_ctl_a", a_ctl, 6'b000111);
    chk("rst_ctl_b", b_ctl, 6'b000111);
    chk_regs("rst");
    reset_n = 1'b1;

    // Table vectors, each a single cycle.
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].rn, tbl[i].rmt, tbl[i].urn, tbl[i].urmt, tbl[i].rd, tbl[i].mr,
             tbl[i].br, tbl[i].req, tbl[i].rdy);
      #1;
      chk("tbl_ctl", a_ctl, tbl[i].exp);
      do_cycle("tbl");
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle("idle");

    // Five-cycle memory wait, then ready.
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) do_cycle("wait5");
    chk("wait5_state_lit", int'(a_st), int'(MEM_WAIT));
    dmem_ready = 1'b1;
    do_cycle("wait5_rdy");
    chk("wait5_run_lit", int'(a_st), int'(RUN));
    chk("wait5_to_a_lit", a_to, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle("idle");

    // Six-cycle wait with a taken branch held: flush deferred to the ready cycle.
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) do_cycle("wait6");
    chk("wait6_to_b_lit", b_to, 1);
    dmem_ready = 1'b1;
    #1;
    chk("defer_flush_ctl", a_ctl, 6'b111111);
    do_cycle("wait6_rdy");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle("idle");
    chk("to_sticky_b", b_to, 1);

    // Reset dropped mid-wait.
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    do_cycle("prerst");
    do_cycle("prerst");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_ctl_a", a_ctl, 6'b000111);
    chk("midrst_ctl_b", b_ctl, 6'b000111);
    chk_regs("midrst");
    @(negedge clock);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    do_cycle("postrst");

    // Twenty stall cycles: small counter saturates at 15.
    set_in(5'd8, 5'd0, 1, 0, 5'd8, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) do_cycle("sat");
    chk("sat_stall_b_lit", b_stall, 15);
    chk("sat_stall_a_lit", a_stall, 20);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] pick[4];
      pick[0] = 5'd1; pick[1] = 5'd2; pick[2] = 5'd31; pick[3] = 5'($urandom_range(0, 31));
      set_in(pick[$urandom_range(0, 3)], pick[$urandom_range(0, 3)],
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             pick[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
             ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      do_cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
